// File: rtl/dma_axi_slave_mem.sv
// dma_axi_slave_mem: AXI4 slave responder over a byte-strobed word memory
package dma_axi_pkg;
  localparam int AXI_AW = 32;
  localparam int AXI_DW = 32;
  localparam logic [1:0] OKAY = 2'd0;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;
  localparam logic [1:0] FIXED = 2'd0;
  localparam logic [1:0] INCR = 2'd1;
  typedef struct packed {
    logic [AXI_AW-1:0] araddr;
    logic [7:0] arlen;
    logic [2:0] arsize;
    logic [1:0] arburst;
    logic arvalid;
    logic [AXI_AW-1:0] awaddr;
    logic [7:0] awlen;
    logic [2:0] awsize;
    logic [1:0] awburst;
    logic awvalid;
    logic [AXI_DW-1:0] wdata;
    logic [AXI_DW/8-1:0] wstrb;
    logic wlast;
    logic wvalid;
    logic rready;
    logic bready;
  } s_axi_mosi_t;
  typedef struct packed {
    logic arready;
    logic awready;
    logic wready;
    logic [AXI_DW-1:0] rdata;
    logic [1:0] rresp;
    logic rlast;
    logic rvalid;
    logic [1:0] bresp;
    logic bvalid;
  } s_axi_miso_t;
endpackage

module dma_axi_slave_mem
  import dma_axi_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter logic [AXI_AW-1:0] BASE_ADDR = '0,
  parameter int RD_WAIT = 0
) (
  input logic clk,
  input logic rst,
  input s_axi_mosi_t axi_mosi_i,
  output s_axi_miso_t axi_miso_o,
  output logic rd_busy_o,
  output logic wr_busy_o
);
  localparam int BYTES = AXI_DW / 8;
  localparam int SZ = $clog2(BYTES);
  localparam int IW = $clog2(MEM_WORDS);
  localparam int XI = IW + 1;
  localparam int XW = AXI_AW + 2;
  localparam logic [XW-1:0] LO = XW'(BASE_ADDR);
  localparam logic [XW-1:0] HI = XW'(BASE_ADDR) + XW'(MEM_WORDS * BYTES);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [AXI_DW-1:0] mem [MEM_WORDS];
  logic aw_hs, w_hs, ar_hs, r_hs, w_bad, w_we, r_issue;
  logic [XI-1:0] w_idx;
  logic w_fixed;
  logic [7:0] w_len, w_beat;
  logic [1:0] w_err, w_resp;
  logic [IW-1:0] r_idx, iss_idx;
  logic r_fixed, iss_fixed;
  logic [7:0] r_len, r_beat, iss_beat, iss_len;
  logic [1:0] r_resp, iss_resp;
  logic [3:0] r_cnt;
  logic rvalid, rlast;
  logic [AXI_DW-1:0] rdata;
  logic [1:0] rresp;

  // Burst classification, decided once at the address handshake; the INCR range check covers the last beat
  function automatic logic [1:0] classify(input logic [AXI_AW-1:0] addr, input logic [7:0] len,
                                          input logic [2:0] size, input logic [1:0] burst);
    logic [XW-1:0] last;
    last = XW'(addr) + (burst == INCR ? XW'(len) << SZ : '0);
    return (size != 3'(SZ) || burst[1]) ? SLVERR : (XW'(addr) < LO || last >= HI) ? DECERR : OKAY;
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [AXI_AW-1:0] addr);
    return IW'((addr - BASE_ADDR) >> SZ);
  endfunction

  // Handshakes, beat issue selection and next-state for both FSMs
  always_comb begin
    aw_hs = axi_mosi_i.awvalid && w_state == W_IDLE;
    w_hs = axi_mosi_i.wvalid && w_state == W_DATA;
    ar_hs = axi_mosi_i.arvalid && r_state == R_IDLE;
    r_hs = rvalid && axi_mosi_i.rready;
    w_bad = axi_mosi_i.wlast != (w_beat == w_len);
    w_we = w_hs && w_err == OKAY && !w_idx[IW];
    iss_idx = r_state == R_IDLE ? word_idx(axi_mosi_i.araddr) : r_idx;
    iss_fixed = r_state == R_IDLE ? axi_mosi_i.arburst == FIXED : r_fixed;
    iss_len = r_state == R_IDLE ? axi_mosi_i.arlen : r_len;
    iss_beat = r_state == R_IDLE ? 8'd0 : r_beat;
    iss_resp = r_state == R_IDLE ? classify(axi_mosi_i.araddr, axi_mosi_i.arlen, axi_mosi_i.arsize, axi_mosi_i.arburst) : r_resp;
    r_issue = (ar_hs && RD_WAIT == 0) || (r_state == R_WAIT && r_cnt == '0) || (r_state == R_DATA && r_hs && !rlast);
    w_next = w_state == W_IDLE ? (aw_hs ? W_DATA : W_IDLE) :
             w_state == W_DATA ? (w_hs && axi_mosi_i.wlast ? W_RESP : W_DATA) :
             (axi_mosi_i.bready ? W_IDLE : W_RESP);
    r_next = r_state == R_IDLE ? (ar_hs ? (RD_WAIT == 0 ? R_DATA : R_WAIT) : R_IDLE) :
             r_state == R_WAIT ? (r_cnt == '0 ? R_DATA : R_WAIT) :
             (r_hs && rlast ? R_IDLE : R_DATA);
  end

  // State registers for the independent read and write channels
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end

  // Write burst context: index walks for INCR and parks once past the top so stray beats never alias
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      w_idx <= '0;
      w_fixed <= 1'b0;
      w_len <= '0;
      w_beat <= '0;
      w_err <= OKAY;
      w_resp <= OKAY;
    end else begin
      if (aw_hs) begin
        w_idx <= {1'b0, word_idx(axi_mosi_i.awaddr)};
        w_fixed <= axi_mosi_i.awburst == FIXED;
        w_len <= axi_mosi_i.awlen;
        w_beat <= '0;
        w_err <= classify(axi_mosi_i.awaddr, axi_mosi_i.awlen, axi_mosi_i.awsize, axi_mosi_i.awburst);
        w_resp <= classify(axi_mosi_i.awaddr, axi_mosi_i.awlen, axi_mosi_i.awsize, axi_mosi_i.awburst);
      end
      if (w_hs) begin
        w_beat <= w_beat + 8'd1;
        w_idx <= w_idx + XI'(!w_fixed && !w_idx[IW]);
        if (w_bad && w_resp == OKAY) w_resp <= SLVERR;
      end
    end

  // Byte-strobed memory write; contents survive reset
  always_ff @(posedge clk)
    if (w_we)
      for (int b = 0; b < BYTES; b++)
        if (axi_mosi_i.wstrb[b]) mem[w_idx[IW-1:0]][8*b +: 8] <= axi_mosi_i.wdata[8*b +: 8];

  // Read burst context and registered R beat, held until rready
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_idx <= '0;
      r_fixed <= 1'b0;
      r_len <= '0;
      r_beat <= '0;
      r_resp <= OKAY;
      r_cnt <= '0;
      rvalid <= 1'b0;
      rlast <= 1'b0;
      rdata <= '0;
      rresp <= OKAY;
    end else begin
      if (ar_hs) begin
        r_idx <= iss_idx;
        r_fixed <= iss_fixed;
        r_len <= iss_len;
        r_beat <= '0;
        r_resp <= iss_resp;
        r_cnt <= 4'(RD_WAIT - 1);
      end
      if (r_state == R_WAIT) r_cnt <= r_cnt - 4'd1;
      if (r_issue) begin
        rvalid <= 1'b1;
        rdata <= iss_resp == OKAY ? mem[iss_idx] : '0;
        rresp <= iss_resp;
        rlast <= iss_beat == iss_len;
        r_idx <= iss_idx + IW'(!iss_fixed);
        r_beat <= iss_beat + 8'd1;
      end else if (r_hs) begin
        rvalid <= 1'b0;
        rlast <= 1'b0;
      end
    end

  // Output bundle; B fields only carry meaning while bvalid
  always_comb begin
    axi_miso_o = '0;
    axi_miso_o.arready = r_state == R_IDLE;
    axi_miso_o.awready = w_state == W_IDLE;
    axi_miso_o.wready = w_state == W_DATA;
    axi_miso_o.rvalid = rvalid;
    axi_miso_o.rdata = rdata;
    axi_miso_o.rresp = rresp;
    axi_miso_o.rlast = rlast;
    axi_miso_o.bvalid = w_state == W_RESP;
    axi_miso_o.bresp = w_state == W_RESP ? w_resp : OKAY;
    rd_busy_o = r_state != R_IDLE;
    wr_busy_o = w_state != W_IDLE;
  end
endmodule

// File: tb/tb_dma_axi_slave_mem.sv
// tb_dma_axi_slave_mem: directed bench with a scoreboard model of the AXI slave memory
module tb_dma_axi_slave_mem;
  import dma_axi_pkg::*;
  localparam int MW = 64;
  localparam logic [31:0] BASE = 32'h100;
  localparam logic [31:0] LAST = BASE + MW * 4 - 4;
  typedef struct {logic [31:0] d; logic [1:0] r; logic l;} beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  s_axi_mosi_t mosi, mosi0, mosi3;
  s_axi_miso_t miso0, miso3, rs;
  logic rb0, wb0, rb3, wb3;
  int rsel = 0;
  int ncmp = 0;
  int nbad = 0;
  logic [31:0] mm [MW];
  beat_t rq[$];
  logic [1:0] bq[$];
  logic [31:0] got_q[$];
  logic [1:0] last_bresp, last_rresp;

  always #5 clk = ~clk;

  always_comb begin
    mosi0 = mosi;
    mosi3 = mosi;
    mosi0.arvalid = mosi.arvalid && rsel == 0;
    mosi3.arvalid = mosi.arvalid && rsel == 1;
  end

  dma_axi_slave_mem #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .RD_WAIT(0)) u0 (
    .clk(clk), .rst(rst), .axi_mosi_i(mosi0), .axi_miso_o(miso0), .rd_busy_o(rb0), .wr_busy_o(wb0));
  dma_axi_slave_mem #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .RD_WAIT(3)) u3 (
    .clk(clk), .rst(rst), .axi_mosi_i(mosi3), .axi_miso_o(miso3), .rd_busy_o(rb3), .wr_busy_o(wb3));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    ncmp++;
    nbad++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  function automatic s_axi_miso_t cur();
    return rsel == 1 ? miso3 : miso0;
  endfunction

  function automatic logic [1:0] cls(input logic [31:0] a, input int len, input int size, input int burst);
    longint first = longint'(a);
    longint fin = first + (burst == 1 ? longint'(len) * 4 : 0);
    if (size != 2 || burst >= 2) return 2'd2;
    if (first < longint'(BASE) || fin >= longint'(BASE) + MW * 4) return 2'd3;
    return 2'd0;
  endfunction

  function automatic int widx(input logic [31:0] a, input int burst, input int i);
    return int'(a - BASE) / 4 + (burst == 1 ? i : 0);
  endfunction

  always @(negedge clk) begin
    s_axi_miso_t m, o;
    m = cur();
    o = rsel == 1 ? miso0 : miso3;
    if (rst) begin
      rq.delete();
      bq.delete();
    end else begin
      chk("r_idle_side", o.rvalid, 1'b0);
      if (m.rvalid) begin
        if (rq.size() == 0) timeout("r_unexpected");
        else begin
          chk("r_beat", {m.rdata, m.rresp, m.rlast}, {rq[0].d, rq[0].r, rq[0].l});
          if (mosi.rready) begin
            got_q.push_back(m.rdata);
            last_rresp = m.rresp;
            void'(rq.pop_front());
          end
        end
      end
      if (miso0.bvalid || miso3.bvalid) begin
        if (bq.size() == 0) timeout("b_unexpected");
        else begin
          chk("bresp0", {miso0.bvalid, miso0.bresp}, {1'b1, bq[0]});
          chk("bresp3", {miso3.bvalid, miso3.bresp}, {1'b1, bq[0]});
          if (mosi.bready) begin
            last_bresp = miso0.bresp;
            void'(bq.pop_front());
          end
        end
      end
    end
  end

  task automatic wr(input logic [31:0] a, input int len, input int burst, input int d0, input logic [3:0] strb,
                    input int nb, input int bdelay, input bit abort, input int size = 2);
    logic [1:0] r;
    logic [31:0] dat;
    int g;
    r = cls(a, len, size, burst);
    @(posedge clk); #1;
    mosi.awaddr = a;
    mosi.awlen = 8'(len);
    mosi.awsize = 3'(size);
    mosi.awburst = 2'(burst);
    mosi.awvalid = 1'b1;
    g = 0;
    @(negedge clk);
    while (!miso0.awready && g < 50) begin g++; @(negedge clk); end
    if (g >= 50) timeout("aw_wait");
    @(posedge clk); #1;
    mosi.awvalid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      dat = 32'(d0 + i);
      mosi.wdata = dat;
      mosi.wstrb = strb;
      mosi.wlast = !abort && i == nb - 1;
      mosi.wvalid = 1'b1;
      g = 0;
      @(negedge clk);
      while (!miso0.wready && g < 50) begin g++; @(negedge clk); end
      if (g >= 50) timeout("w_wait");
      if (r == 2'd0 && widx(a, burst, i) < MW)
        for (int b = 0; b < 4; b++) if (strb[b]) mm[widx(a, burst, i)][8*b +: 8] = dat[8*b +: 8];
      if (mosi.wlast) bq.push_back(r != 2'd0 ? r : (nb != len + 1 ? 2'd2 : 2'd0));
      @(posedge clk); #1;
    end
    mosi.wvalid = 1'b0;
    mosi.wlast = 1'b0;
    if (!abort) begin
      @(negedge clk);
      chk("b_timing", miso0.bvalid, 1'b1);
      for (int i = 0; i < bdelay; i++) begin
        @(negedge clk);
        chk("b_stall", {miso0.bvalid, miso0.awready, miso0.bresp}, {2'b10, bq.size() > 0 ? bq[0] : 2'bxx});
      end
      @(posedge clk); #1;
      mosi.bready = 1'b1;
      g = 0;
      @(negedge clk);
      while (!miso0.bvalid && g < 50) begin g++; @(negedge clk); end
      if (g >= 50) timeout("b_wait");
      @(posedge clk); #1;
      mosi.bready = 1'b0;
    end
  endtask

  task automatic rd(input logic [31:0] a, input int len, input int burst, input int sel, input int stall_at,
                    input int stall_len, input int abort_at, input int size = 2);
    logic [1:0] r;
    int g, got, sl;
    r = cls(a, len, size, burst);
    for (int i = 0; i <= len; i++)
      rq.push_back('{d: (r == 2'd0) ? mm[widx(a, burst, i)] : 32'd0, r: r, l: i == len});
    got_q.delete();
    rsel = sel;
    @(posedge clk); #1;
    mosi.araddr = a;
    mosi.arlen = 8'(len);
    mosi.arsize = 3'(size);
    mosi.arburst = 2'(burst);
    mosi.arvalid = 1'b1;
    mosi.rready = 1'b1;
    g = 0;
    @(negedge clk);
    while (!cur().arready && g < 50) begin g++; @(negedge clk); end
    if (g >= 50) timeout("ar_wait");
    @(posedge clk); #1;
    mosi.arvalid = 1'b0;
    g = 1;
    @(negedge clk);
    while (!cur().rvalid && g < 40) begin g++; @(negedge clk); end
    chk("r_latency", g, sel == 1 ? 4 : 1);
    got = 0;
    sl = stall_len;
    g = 0;
    while (got <= len && got != abort_at && g < 300) begin
      if (cur().rvalid && mosi.rready) got++;
      else if (!mosi.rready) chk("r_hold", cur().rvalid, 1'b1);
      @(posedge clk); #1;
      if (got == stall_at && sl > 0) begin mosi.rready = 1'b0; sl--; end
      else mosi.rready = 1'b1;
      @(negedge clk);
      g++;
    end
    if (g >= 300) timeout("r_burst");
    else if (got > len) chk("r_done", {cur().rvalid, cur().arready}, 2'b01);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    mosi = '0;
    rs = '0;
    rs.arready = 1'b1;
    rs.awready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_miso", miso0, rs);
    chk("reset_busy", {rb0, wb0, rb3, wb3}, 4'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_miso0", miso0, rs);
    chk("idle_miso3", miso3, rs);
    // INCR write then readback
    wr(BASE + 32'h10, 3, 1, 32'hA0, 4'hF, 4, 0, 1'b0);
    chk("t1_bresp", last_bresp, 2'd0);
    rd(BASE + 32'h10, 3, 1, 0, -1, 0, -1);
    chk("t1_n", got_q.size(), 4);
    chk("t1_d0", got_q[0], 32'hA0);
    chk("t1_d3", got_q[3], 32'hA3);
    // byte strobes
    wr(BASE + 32'h30, 0, 1, 32'hFFFFFFFF, 4'hF, 1, 0, 1'b0);
    wr(BASE + 32'h30, 0, 1, 32'h11223344, 4'b0011, 1, 0, 1'b0);
    rd(BASE + 32'h30, 0, 1, 0, -1, 0, -1);
    chk("t2_strb", got_q[0], 32'hFFFF3344);
    // decode and slave errors
    wr(LAST, 0, 1, 32'h5A5A5A5A, 4'hF, 1, 0, 1'b0);
    rd(LAST, 1, 1, 0, -1, 0, -1);
    chk("t3_rd_decerr", {got_q[1], last_rresp}, {32'd0, 2'd3});
    wr(LAST, 1, 1, 32'h12345678, 4'hF, 2, 0, 1'b0);
    chk("t3_wr_decerr", last_bresp, 2'd3);
    rd(LAST, 0, 1, 0, -1, 0, -1);
    chk("t3_unchanged", got_q[0], 32'h5A5A5A5A);
    rd(BASE, 0, 1, 0, -1, 0, -1, 1);
    chk("t3_size", {got_q[0], last_rresp}, {32'd0, 2'd2});
    rd(BASE + 32'h10, 1, 2, 0, -1, 0, -1);
    chk("t3_wrap", last_rresp, 2'd2);
    // read wait states, R stall, B stall
    wr(BASE + 32'h40, 3, 1, 32'hC0, 4'hF, 4, 4, 1'b0);
    rd(BASE + 32'h40, 3, 1, 1, 1, 5, -1);
    chk("t4_d1", got_q[1], 32'hC1);
    chk("t4_d3", got_q[3], 32'hC3);
    rsel = 0;
    // FIXED burst and early wlast
    wr(BASE + 32'h50, 3, 0, 1, 4'hF, 4, 0, 1'b0);
    rd(BASE + 32'h50, 0, 1, 0, -1, 0, -1);
    chk("t5_fixed", got_q[0], 32'd4);
    rd(BASE + 32'h50, 2, 0, 0, -1, 0, -1);
    chk("t5_fixed_rd", got_q[2], 32'd4);
    wr(BASE + 32'h60, 3, 1, 32'h77, 4'hF, 2, 0, 1'b0);
    chk("t5_early_last", last_bresp, 2'd2);
    // reset in the middle of a read and a write
    wr(BASE + 32'h80, 7, 1, 32'h700, 4'hF, 8, 0, 1'b0);
    wr(BASE + 32'h80, 7, 1, 32'hE0, 4'hF, 2, 0, 1'b1);
    rd(BASE + 32'h80, 7, 1, 0, -1, 0, 2);
    chk("t6_busy_pre", {rb0, wb0}, 2'b11);
    @(posedge clk); #1;
    rst = 1'b1;
    mosi = '0;
    @(negedge clk);
    chk("t6_rst_miso", miso0, rs);
    chk("t6_rst_busy", {rb0, wb0}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    rd(BASE + 32'h80, 7, 1, 0, -1, 0, -1);
    chk("t6_partial", got_q[1], 32'hE1);
    chk("t6_kept", got_q[2], 32'h702);
    repeat (3) @(posedge clk);
    chk("final_queues", {32'(rq.size()), 32'(bq.size())}, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
